// File: rtl/crossroad1_core_oci_pkg.sv
// Shared on-chip-instruction-trace definitions: DCT record codes, frame widths
// and the packed frame payload carried by the output slot.
package crossroad1_core_oci_pkg;

   localparam int DCT_BUF_W  = 30;
   localparam int DCT_CNT_W  = 4;
   localparam int DCT_CODE_W = 2;
   localparam int SLOT_W     = DCT_BUF_W + DCT_CNT_W;

   localparam logic [DCT_CODE_W-1:0] DCT_TAKEN     = 2'b01;
   localparam logic [DCT_CODE_W-1:0] DCT_NOT_TAKEN = 2'b10;
   localparam logic [DCT_CODE_W-1:0] DCT_ERET      = 2'b11;

   typedef struct packed {
      logic [DCT_CNT_W-1:0] count;
      logic [DCT_BUF_W-1:0] buffer;
   } dct_frame_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/crossroad1_core_oci_frame_slot.sv
// One-entry valid/ready holding register for completed DCT frames; a load
// in the same cycle as a drain refills the slot without a bubble.
module crossroad1_core_oci_frame_slot
   import crossroad1_core_oci_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  dct_frame_t load_data,
   input  logic       ready,
   output logic       slot_free,
   output logic       valid,
   output dct_frame_t data
);

   logic       valid_r;
   dct_frame_t data_r;

   assign slot_free = !valid_r || ready;
   assign valid     = valid_r;
   assign data      = data_r;

   // Slot occupancy and payload; payload only changes on load so it stays stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= '{count: 4'd0, buffer: 30'd0};
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= load_data;
      end else if (ready) begin
         valid_r <= 1'b0;
      end
   end

endmodule

// File: rtl/crossroad1_core_cpu_0_oci_dct_packer.sv
// Packs 2-bit DCT records into 30-bit trace frames of up to MAX_ENTRIES records
// and hands completed frames to a single-entry valid/ready slot.
module crossroad1_core_cpu_0_oci_dct_packer
   import crossroad1_core_oci_pkg::*;
#(
   parameter int MAX_ENTRIES = 15
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        trace_enable,
   input  logic        dct_valid,
   input  logic [1:0]  dct_code,
   input  logic        flush,
   input  logic        frame_ready,
   output logic        frame_valid,
   output logic [29:0] frame_buffer,
   output logic [3:0]  frame_count,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        overflow,
   output logic [7:0]  drop_count
);

   localparam logic [DCT_CNT_W-1:0] MAX_CNT = DCT_CNT_W'(MAX_ENTRIES);

   logic [DCT_BUF_W-1:0] acc_r;
   logic [DCT_CNT_W-1:0] cnt_r;
   logic                 flush_pending_r;
   logic                 overflow_r;
   logic [7:0]           drop_count_r;

   logic [DCT_BUF_W-1:0] acc_nxt_s;
   logic [DCT_CNT_W-1:0] cnt_nxt_s;
   logic                 drop_s;
   logic                 emit_req_s;
   logic                 emit_s;
   logic                 slot_free_s;
   dct_frame_t           slot_load_s;
   dct_frame_t           slot_data_s;

   // Next accumulator contents and the emit decision for this cycle.
   always_comb begin
      acc_nxt_s  = acc_r;
      cnt_nxt_s  = cnt_r;
      drop_s     = 1'b0;
      if (trace_enable && dct_valid) begin
         if (cnt_r != MAX_CNT) begin
            acc_nxt_s = {acc_r[DCT_BUF_W-3:0], dct_code};
            cnt_nxt_s = cnt_r + 4'd1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         drop_s = 1'b0;
      end
      emit_req_s  = trace_enable &&
                    ((cnt_nxt_s == MAX_CNT) ||
                     ((flush || flush_pending_r) && (cnt_nxt_s != 4'd0)));
      emit_s      = emit_req_s && slot_free_s;
      slot_load_s = '{count: cnt_nxt_s, buffer: acc_nxt_s};
   end

   // Accumulator, pending flush and drop bookkeeping; all frozen while tracing is disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r           <= 30'd0;
         cnt_r           <= 4'd0;
         flush_pending_r <= 1'b0;
         overflow_r      <= 1'b0;
         drop_count_r    <= 8'd0;
      end else begin
         if (emit_s) begin
            acc_r           <= 30'd0;
            cnt_r           <= 4'd0;
            flush_pending_r <= 1'b0;
         end else if (trace_enable) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
            if (flush && (cnt_nxt_s != 4'd0)) begin
               flush_pending_r <= 1'b1;
            end
         end
         if (drop_s) begin
            overflow_r   <= 1'b1;
            drop_count_r <= sat_inc8(drop_count_r);
         end
      end
   end

   crossroad1_core_oci_frame_slot u_slot (
      .clk       (clk),
      .rst_n     (reset_n),
      .load      (emit_s),
      .load_data (slot_load_s),
      .ready     (frame_ready),
      .slot_free (slot_free_s),
      .valid     (frame_valid),
      .data      (slot_data_s)
   );

   assign frame_buffer = slot_data_s.buffer;
   assign frame_count  = slot_data_s.count;
   assign dct_buffer   = acc_r;
   assign dct_count    = cnt_r;
   assign overflow     = overflow_r;
   assign drop_count   = drop_count_r;

endmodule

// File: tb/tb_crossroad1_core_cpu_0_oci_dct_packer.sv
// Directed bench for the DCT packer: expected frames are queued as stimulus is
// driven and popped by a monitor whenever the output slot hands a frame off.
module tb_crossroad1_core_cpu_0_oci_dct_packer;

   typedef struct packed {
      logic [3:0]  cnt;
      logic [29:0] data;
   } exp_frame_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trace_enable;
   logic        dct_valid;
   logic [1:0]  dct_code;
   logic        flush;
   logic        frame_ready;
   logic        frame_valid;
   logic [29:0] frame_buffer;
   logic [3:0]  frame_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        overflow;
   logic [7:0]  drop_count;

   int checks = 0;
   int failures = 0;
   exp_frame_t sb_q[$];
   exp_frame_t f1;
   exp_frame_t f2;

   always #5 clk = ~clk;

   crossroad1_core_cpu_0_oci_dct_packer #(.MAX_ENTRIES(15)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .trace_enable (trace_enable),
      .dct_valid    (dct_valid),
      .dct_code     (dct_code),
      .flush        (flush),
      .frame_ready  (frame_ready),
      .frame_valid  (frame_valid),
      .frame_buffer (frame_buffer),
      .frame_count  (frame_count),
      .dct_buffer   (dct_buffer),
      .dct_count    (dct_count),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus; returns 1 time unit after the consuming edge.
   task automatic cyc(input logic v, input logic [1:0] c, input logic f);
      dct_valid = v;
      dct_code  = c;
      flush     = f;
      @(posedge clk);
      #1;
      dct_valid = 1'b0;
      dct_code  = 2'b00;
      flush     = 1'b0;
   endtask

   function automatic logic [29:0] pack3(input int first, input int n);
      logic [29:0] acc = 30'd0;
      for (int i = first; i < first + n; i++) acc = {acc[27:0], 2'((i % 3) + 1)};
      return acc;
   endfunction

   // Scoreboard: every handshake must match the oldest expected frame.
   always @(negedge clk) begin
      if (reset_n && frame_valid && frame_ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
         end else begin
            exp_frame_t e;
            e = sb_q.pop_front();
            check("sb_frame_count", {28'd0, frame_count}, {28'd0, e.cnt});
            check("sb_frame_buffer", {2'd0, frame_buffer}, {2'd0, e.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; trace_enable = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
      flush = 1'b0; frame_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
      check("rst_frame_buffer", {2'd0, frame_buffer}, 32'd0);
      check("rst_frame_count", {28'd0, frame_count}, 32'd0);
      check("rst_dct_count", {28'd0, dct_count}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_drop_count", {24'd0, drop_count}, 32'd0);
      reset_n = 1'b1; trace_enable = 1'b1; frame_ready = 1'b1;

      // Fill: 15 alternating records produce one full frame.
      sb_q.push_back('{cnt: 4'd15, data: 30'h1999_9999});
      for (int i = 0; i < 15; i++) cyc(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
      check("fill_valid", {31'd0, frame_valid}, 32'd1);
      check("fill_count", {28'd0, frame_count}, 32'd15);
      check("fill_buffer", {2'd0, frame_buffer}, 32'h1999_9999);
      check("fill_acc_cnt", {28'd0, dct_count}, 32'd0);
      check("fill_acc_buf", {2'd0, dct_buffer}, 32'd0);
      cyc(1'b0, 2'b00, 1'b0);
      check("fill_drained", {31'd0, frame_valid}, 32'd0);

      // Partial flush, then flush of an empty accumulator.
      sb_q.push_back('{cnt: 4'd3, data: 30'h016});
      cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b10, 1'b0);
      check("part_acc_cnt", {28'd0, dct_count}, 32'd3);
      check("part_acc_buf", {2'd0, dct_buffer}, 32'h016);
      cyc(1'b0, 2'b00, 1'b1);
      check("part_valid", {31'd0, frame_valid}, 32'd1);
      check("part_count", {28'd0, frame_count}, 32'd3);
      cyc(1'b0, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b1);
      check("empty_flush_valid", {31'd0, frame_valid}, 32'd0);
      cyc(1'b0, 2'b00, 1'b0);
      check("empty_flush_valid2", {31'd0, frame_valid}, 32'd0);

      // Backpressure: 30 records fill slot and accumulator, 2 more are dropped.
      frame_ready = 1'b0;
      f1 = '{cnt: 4'd15, data: pack3(0, 15)};
      f2 = '{cnt: 4'd15, data: pack3(15, 15)};
      sb_q.push_back(f1);
      sb_q.push_back(f2);
      for (int i = 0; i < 32; i++) cyc(1'b1, 2'((i % 3) + 1), 1'b0);
      check("bp_valid", {31'd0, frame_valid}, 32'd1);
      check("bp_hold_count", {28'd0, frame_count}, 32'd15);
      check("bp_hold_buffer", {2'd0, frame_buffer}, {2'd0, f1.data});
      check("bp_acc_cnt", {28'd0, dct_count}, 32'd15);
      check("bp_acc_buf", {2'd0, dct_buffer}, {2'd0, f2.data});
      check("bp_overflow", {31'd0, overflow}, 32'd1);
      check("bp_drop_count", {24'd0, drop_count}, 32'd2);
      frame_ready = 1'b1;
      cyc(1'b0, 2'b00, 1'b0);
      check("bp_reload_valid", {31'd0, frame_valid}, 32'd1);
      check("bp_reload_buffer", {2'd0, frame_buffer}, {2'd0, f2.data});
      check("bp_reload_acc", {28'd0, dct_count}, 32'd0);
      cyc(1'b0, 2'b00, 1'b0);
      check("bp_drained", {31'd0, frame_valid}, 32'd0);

      // Flush while the slot is busy is remembered until the slot frees.
      frame_ready = 1'b0;
      sb_q.push_back('{cnt: 4'd1, data: 30'h3});
      cyc(1'b1, 2'b11, 1'b1);
      cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b10, 1'b0);
      cyc(1'b0, 2'b00, 1'b1);
      cyc(1'b0, 2'b00, 1'b0);
      check("fb_held_count", {28'd0, frame_count}, 32'd1);
      check("fb_acc_cnt", {28'd0, dct_count}, 32'd2);
      sb_q.push_back('{cnt: 4'd2, data: 30'h6});
      frame_ready = 1'b1;
      cyc(1'b0, 2'b00, 1'b0);
      check("fb_emit_count", {28'd0, frame_count}, 32'd2);
      check("fb_emit_acc", {28'd0, dct_count}, 32'd0);
      cyc(1'b0, 2'b00, 1'b0);

      // Record together with flush lands in the flushed frame.
      sb_q.push_back('{cnt: 4'd5, data: 30'h19B});
      cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b10, 1'b0);
      cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b10, 1'b0);
      cyc(1'b1, 2'b11, 1'b1);
      check("sim_count", {28'd0, frame_count}, 32'd5);
      check("sim_newest", {30'd0, frame_buffer[1:0]}, 32'd3);
      cyc(1'b0, 2'b00, 1'b0);

      // Reset mid-operation with a full slot and 7 accumulated records.
      frame_ready = 1'b0;
      cyc(1'b1, 2'b01, 1'b1);
      for (int i = 0; i < 7; i++) cyc(1'b1, 2'b10, 1'b0);
      check("pre_rst_cnt", {28'd0, dct_count}, 32'd7);
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
      check("mid_rst_count", {28'd0, dct_count}, 32'd0);
      check("mid_rst_drop", {24'd0, drop_count}, 32'd0);
      check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1; frame_ready = 1'b1;

      // Disabled tracing holds the accumulator; re-enable continues from it.
      cyc(1'b1, 2'b01, 1'b0); cyc(1'b1, 2'b10, 1'b0);
      trace_enable = 1'b0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 1'b1);
      check("dis_cnt", {28'd0, dct_count}, 32'd2);
      check("dis_valid", {31'd0, frame_valid}, 32'd0);
      trace_enable = 1'b1;
      sb_q.push_back('{cnt: 4'd3, data: 30'h1B});
      cyc(1'b1, 2'b11, 1'b0);
      check("reen_cnt", {28'd0, dct_count}, 32'd3);
      cyc(1'b0, 2'b00, 1'b1);
      repeat (3) cyc(1'b0, 2'b00, 1'b0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crossroad1_core_cpu_0_oci_dct_packer.md
# crossroad1_core_cpu_0_oci_dct_packer

Packs 2-bit direct-control-transfer (DCT) records from the CPU's on-chip-instruction-trace path into 30-bit trace frames of up to 15 records. The block sits between the instruction-trace decode and the trace FIFO/test-bench monitor. It exposes the live accumulator as `dct_buffer`/`dct_count`, the signals the OCI test bench consumes. Completed frames leave through a single-entry valid/ready output slot.

## Interface
Parameters:
- `MAX_ENTRIES`, 15: records per full frame, legal range 1..15. `dct_buffer` width fixed at 30, `dct_count` width fixed at 4.

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `trace_enable`  in  1  accumulation enabled
- `dct_valid`  in  1  one DCT record presented this cycle
- `dct_code`  in  2  record code (01 taken, 10 not-taken, 11 exception-return, 00 reserved, packed as given)
- `flush`  in  1  force emission of partial frame (indirect jump, trace stop)
- `frame_ready`  in  1  downstream accepts slot this cycle
- `frame_valid`  out  1  output slot holds a frame
- `frame_buffer`  out  30  packed frame, newest record in bits [1:0]
- `frame_count`  out  4  records in frame, 1..MAX_ENTRIES
- `dct_buffer`  out  30  live accumulator
- `dct_count`  out  4  live accumulator record count
- `overflow`  out  1  sticky: a record was dropped since reset
- `drop_count`  out  8  saturating count of dropped records

## Operation
- Slot free condition: `slot_free = !frame_valid || frame_ready`.
- Accept: when `trace_enable && dct_valid && dct_count != MAX_ENTRIES`, `acc' = {dct_buffer[27:0], dct_code}` and `cnt' = dct_count + 1`. Otherwise `acc'`/`cnt'` equal the current values.
- Drop: when `trace_enable && dct_valid && dct_count == MAX_ENTRIES` (full, blocked), the record is discarded, `overflow` is set, and `drop_count` increments, saturating at 255.
- Emit request: `cnt' == MAX_ENTRIES`, or (`flush` or `flush_pending`) with `cnt' != 0`.
- Emit when the request is active and `slot_free`:
  - `frame_buffer <= acc'`, `frame_count <= cnt'`, `frame_valid <= 1`.
  - Accumulator cleared to 0/0.
  - `flush_pending` cleared.
- Emit request active but slot busy: accumulator takes `acc'`/`cnt'`, and `flush` sets `flush_pending`.
- Flush with `cnt' == 0` emits nothing and does not set `flush_pending`.
- Slot drain: `frame_ready && frame_valid` with no new emit sets `frame_valid <= 0`. A simultaneous drain and emit reloads the slot with `frame_valid` staying 1.
- `trace_enable` low:
  - Accumulator, `flush_pending`, `dct_valid`, and `flush` are ignored and held.
  - The slot still drains.
  - On re-enable, operation continues from the held state.
- Unused high bits of a partial frame are 0, because the accumulator is cleared on emit and on reset.

## Timing
- Reset values: all outputs 0, `flush_pending` 0.
- Reset mid-operation discards the accumulator, slot contents, and counters immediately, with no frame emitted.
- Record latency: the record appears in `dct_buffer`/`dct_count` one cycle after acceptance.
- Frame latency: `frame_valid` rises on the edge after the completing record or flush. The accumulator reads 0 that same cycle.
- Back-to-back frames are supported with no bubble while `frame_ready` stays 1.
- `frame_buffer`/`frame_count` are stable while `frame_valid && !frame_ready`.
- Simultaneous `dct_valid` and `flush`: the record is included in the flushed frame.

## Structure
- Shared package `crossroad1_core_oci_pkg`:
  - constants `DCT_BUF_W = 30`, `DCT_CNT_W = 4`, `DCT_CODE_W = 2`
  - code localparams `DCT_TAKEN`, `DCT_NOT_TAKEN`, `DCT_ERET`
- Natural sub-module: `crossroad1_core_oci_frame_slot`, a one-entry valid/ready register holding 34 bits of payload.
- The accumulator, drop logic, and `flush_pending` stay in the top level.

## Test plan
- Fill: 15 accepts of codes 01,10,01,… with `frame_ready = 1` → one cycle after the 15th, `frame_valid = 1`, `frame_count = 15`, `frame_buffer = 30'h1999_9999 >> 0` pattern with newest at [1:0]; accumulator reads 0.
- Partial flush: 3 records 01,01,10 then `flush` → `frame_count = 3`, `frame_buffer = 30'h016`. Then `flush` with an empty accumulator → no frame.
- Backpressure drop: `frame_ready = 0`, 30 records then 2 more → first frame held stable, accumulator at 15, `overflow = 1`, `drop_count = 2`. Raise `frame_ready` → second frame emitted on the next edge.
- Flush while busy: slot busy, 2 records, 1-cycle `flush` → `flush_pending` held. After `frame_ready`, a frame with `frame_count = 2` is emitted.
- Simultaneous: `dct_valid` (code 11) with `flush` at count 4 → `frame_count = 5`, `frame_buffer[1:0] = 11`.
- Reset/enable: assert `reset_n = 0` at count 7 with a full slot → all outputs 0. With `trace_enable = 0`, 5 records → `dct_count` stays 0.
